// File: rtl/spiflash_emu.sv
// SPI NOR flash slave emulator, oversampled in the clk domain.
// Serves 0x03/0x0B/0x6B/0x9F/0x05 from a backdoor-loaded byte array.
module spiflash_emu #(
    parameter int          MEM_BYTES    = 4096,
    parameter int          ADDR_BITS    = 24,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4016
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_sck,
    input  logic                         spi_cs_n,
    input  logic [3:0]                   spi_dq_i,
    output logic [3:0]                   spi_dq_o,
    output logic [3:0]                   spi_dq_oe,
    input  logic                         load_en,
    input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
    input  logic [7:0]                   load_data
);

    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_ID     = 3'd5;
    localparam logic [2:0] S_STAT   = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;

    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic [7:0]    mem [MEM_BYTES];

    logic [1:0]    sck_s;
    logic [1:0]    cs_s;
    logic [3:0]    dq_s0;
    logic [3:0]    dq_s1;
    logic          sck_d;
    logic          sck_rise;
    logic          sck_fall;
    logic          cs_q;
    logic          mosi;
    logic          unused_dq;

    logic [2:0]    state;
    logic [7:0]    cmd;
    logic [7:0]    cmd_next;
    logic [7:0]    cnt;
    logic [2:0]    bcnt;
    logic [2:0]    byte_last;
    logic [AW-1:0] idx;
    logic [1:0]    id_sel;
    logic [7:0]    id_byte;
    logic          quad;
    logic          pend;
    logic [7:0]    sr;

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_s <= '0;
            cs_s  <= '1;
            dq_s0 <= '0;
            dq_s1 <= '0;
            sck_d <= 1'b0;
        end else begin
            sck_s <= {sck_s[0], spi_sck};
            cs_s  <= {cs_s[0], spi_cs_n};
            dq_s0 <= spi_dq_i;
            dq_s1 <= dq_s0;
            sck_d <= sck_s[1];
        end
    end

    assign sck_rise  = sck_s[1] & ~sck_d;
    assign sck_fall  = ~sck_s[1] & sck_d;
    assign cs_q      = cs_s[1];
    assign mosi      = dq_s1[0];
    assign unused_dq = ^dq_s1[3:1];
    assign cmd_next  = {cmd[6:0], mosi};
    assign byte_last = quad ? 3'd1 : 3'd7;

    always_comb begin
        id_byte = JEDEC_ID[7:0];
        case (id_sel)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            spi_dq_o  <= '0;
            spi_dq_oe <= '0;
            cmd       <= '0;
            cnt       <= '0;
            bcnt      <= '0;
            idx       <= '0;
            id_sel    <= '0;
            quad      <= 1'b0;
            pend      <= 1'b0;
            sr        <= '0;
        end else if (cs_q) begin
            state     <= S_IDLE;
            spi_dq_o  <= '0;
            spi_dq_oe <= '0;
            cnt       <= '0;
            bcnt      <= '0;
            pend      <= 1'b0;
        end else begin
            pend <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    state <= S_CMD;
                    cnt   <= '0;
                end
                S_CMD: begin
                    if (sck_rise) begin
                        cmd <= cmd_next;
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'd7) begin
                            cnt    <= '0;
                            bcnt   <= '0;
                            id_sel <= '0;
                            quad   <= (cmd_next == 8'h6B);
                            case (cmd_next)
                                8'h03, 8'h0B, 8'h6B: state <= S_ADDR;
                                8'h9F: begin
                                    state <= S_ID;
                                    pend  <= 1'b1;
                                end
                                8'h05: begin
                                    state <= S_STAT;
                                    pend  <= 1'b1;
                                end
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    // only the low AW address bits survive the shift
                    if (sck_rise) begin
                        idx <= {idx[AW-2:0], mosi};
                        cnt <= cnt + 8'd1;
                        if (cnt == ADDR_LAST) begin
                            cnt <= '0;
                            if (cmd == 8'h03 || DUMMY_CYCLES == 0) begin
                                state <= S_DATA;
                                pend  <= 1'b1;
                            end else begin
                                state <= S_DUMMY;
                            end
                        end
                    end
                end
                S_DUMMY: begin
                    if (sck_rise) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == DUMMY_LAST) begin
                            cnt   <= '0;
                            state <= S_DATA;
                            pend  <= 1'b1;
                        end
                    end
                end
                S_DATA, S_ID, S_STAT: begin
                    if (pend) begin
                        if (state == S_DATA) begin
                            sr <= mem[idx];
                        end else if (state == S_ID) begin
                            sr <= id_byte;
                        end else begin
                            sr <= 8'h00;
                        end
                    end else if (sck_fall) begin
                        if (quad) begin
                            spi_dq_o  <= sr[7:4];
                            spi_dq_oe <= 4'b1111;
                            sr        <= {sr[3:0], 4'b0000};
                        end else begin
                            spi_dq_o  <= {2'b00, sr[7], 1'b0};
                            spi_dq_oe <= 4'b0010;
                            sr        <= {sr[6:0], 1'b0};
                        end
                    end
                    if (sck_rise) begin
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == byte_last) begin
                            bcnt   <= '0;
                            pend   <= 1'b1;
                            idx    <= idx + 1'b1;
                            id_sel <= (id_sel == 2'd2) ? 2'd0 : id_sel + 2'd1;
                        end
                    end
                end
                S_IGNORE: begin
                    spi_dq_oe <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spiflash_emu.sv
// Directed plus random bench for spiflash_emu against a byte-array model.
module tb_spiflash_emu;

    localparam int MB   = 256;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic [3:0] spi_dq_i = '0;
    logic [3:0] spi_dq_o;
    logic [3:0] spi_dq_oe;
    logic       load_en = 1'b0;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m [MB];
    logic [3:0] samp_dq [$];
    logic [3:0] samp_oe [$];
    logic [7:0] exp_q [$];

    spiflash_emu #(
        .MEM_BYTES(MB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_dq_i (spi_dq_i),
        .spi_dq_o (spi_dq_o),
        .spi_dq_oe(spi_dq_oe),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic backdoor(input int a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = 8'(a);
        load_data = d;
        #10;
        load_en   = 1'b0;
        mem_m[a % MB] = d;
    endtask

    task automatic clk_bit(input logic b);
        spi_dq_i = {3'b000, b};
        #HALF;
        samp_dq.push_back(spi_dq_o);
        samp_oe.push_back(spi_dq_oe);
        spi_sck = 1'b1;
        #HALF;
        spi_sck = 1'b0;
    endtask

    task automatic start();
        @(negedge clk);
        samp_dq.delete();
        samp_oe.delete();
        spi_cs_n = 1'b0;
        #20;
    endtask

    task automatic stop();
        #HALF;
        spi_cs_n = 1'b1;
        #100;
    endtask

    task automatic header(input logic [7:0] c, input logic [23:0] a,
                          input int abits, input int dcyc);
        for (int i = 7; i >= 0; i--) clk_bit(c[i]);
        for (int i = 0; i < abits; i++) clk_bit(a[23-i]);
        for (int i = 0; i < dcyc; i++) clk_bit(1'($urandom));
    endtask

    // wr_at < 0 means no backdoor write during the data phase
    task automatic xact(input logic [7:0] c, input logic [23:0] a,
                        input int abits, input int dcyc, input int dclk,
                        input int wr_at, input int wa, input logic [7:0] wd);
        start();
        header(c, a, abits, dcyc);
        for (int i = 0; i < dclk; i++) begin
            if (i == wr_at) backdoor(wa, wd);
            clk_bit(1'($urandom));
        end
        stop();
    endtask

    task automatic check(input string tag, input int hdr, input bit q);
        int         bad;
        logic [7:0] got;
        logic [3:0] oe_req;
        int         per;
        bad    = 0;
        oe_req = q ? 4'hF : 4'h2;
        per    = q ? 2 : 8;
        for (int i = 0; i < samp_oe.size(); i++) begin
            if (i < hdr && samp_oe[i] !== 4'h0) bad++;
            if (i >= hdr && samp_oe[i] !== oe_req) bad++;
        end
        n_tests++;
        assert (bad === 0) else begin
            n_fail++;
            $error("FAIL %s_oe: %0d bad samples, required 0", tag, bad);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            got = '0;
            for (int b = 0; b < per; b++) begin
                if (q) got = {got[3:0], samp_dq[hdr + k*per + b]};
                else   got = {got[6:0], samp_dq[hdr + k*per + b][1]};
            end
            n_tests++;
            assert (got === exp_q[k]) else begin
                n_fail++;
                $error("FAIL %s_b%0d: got %h, expected %h", tag, k, got, exp_q[k]);
            end
        end
    endtask

    task automatic exp_read(input logic [23:0] a, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(mem_m[(int'(a) + k) % MB]);
    endtask

    initial begin
        logic [7:0]  c;
        logic [23:0] a;
        logic [7:0]  old0;
        int          nb;
        bit          q;
        int          hdr;

        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        assert (spi_dq_oe === 4'h0) else begin
            n_fail++;
            $error("FAIL reset_oe: got %h, expected 0", spi_dq_oe);
        end
        n_tests++;
        assert (spi_dq_o === 4'h0) else begin
            n_fail++;
            $error("FAIL reset_dq: got %h, expected 0", spi_dq_o);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < MB; i++) backdoor(i, 8'($urandom));

        backdoor(0, 8'h37);
        backdoor(1, 8'h05);
        backdoor(2, 8'h00);
        backdoor(3, 8'h10);
        xact(8'h03, 24'h000000, 24, 0, 32, -1, 0, 8'h00);
        exp_q = '{8'h37, 8'h05, 8'h00, 8'h10};
        check("read03", 32, 0);

        backdoor(MB - 1, 8'hA5);
        backdoor(0, 8'h5A);
        xact(8'h0B, 24'h000FFF, 24, 8, 16, -1, 0, 8'h00);
        exp_q = '{8'hA5, 8'h5A};
        check("fast_wrap", 40, 0);

        backdoor(2, 8'hC3);
        backdoor(3, 8'h96);
        xact(8'h6B, 24'h000002, 24, 8, 4, -1, 0, 8'h00);
        exp_q = '{8'hC3, 8'h96};
        check("quad", 40, 1);

        xact(8'h9F, 24'h0, 0, 0, 48, -1, 0, 8'h00);
        exp_q = '{8'hEF, 8'h40, 8'h16, 8'hEF, 8'h40, 8'h16};
        check("jedec", 8, 0);

        xact(8'h05, 24'h0, 0, 0, 16, -1, 0, 8'h00);
        exp_q = '{8'h00, 8'h00};
        check("status", 8, 0);

        xact(8'h03, 24'h000000, 12, 0, 0, -1, 0, 8'h00);
        exp_q.delete();
        check("abort", 20, 0);
        xact(8'h03, 24'h000001, 24, 0, 8, -1, 0, 8'h00);
        exp_read(24'h000001, 1);
        check("after_abort", 32, 0);

        start();
        header(8'h03, 24'h000000, 24, 0);
        for (int i = 0; i < 5; i++) clk_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        assert (spi_dq_oe === 4'h0) else begin
            n_fail++;
            $error("FAIL rst_mid_oe: got %h, expected 0", spi_dq_oe);
        end
        n_tests++;
        assert (spi_dq_o === 4'h0) else begin
            n_fail++;
            $error("FAIL rst_mid_dq: got %h, expected 0", spi_dq_o);
        end
        @(negedge clk);
        spi_cs_n = 1'b1;
        rst_n    = 1'b1;
        #200;

        xact(8'hAB, 24'h0, 0, 0, 32, -1, 0, 8'h00);
        exp_q.delete();
        check("ignore", 40, 0);

        exp_read(24'h000000, MB + 1);
        old0 = mem_m[0];
        exp_q[0]  = old0;
        exp_q[MB] = 8'hFF;
        xact(8'h03, 24'h000000, 24, 0, (MB + 1) * 8, 16, 0, 8'hFF);
        check("backdoor", 32, 0);

        for (int t = 0; t < 5; t++) begin
            case ($urandom_range(0, 2))
                0:       c = 8'h03;
                1:       c = 8'h0B;
                default: c = 8'h6B;
            endcase
            a   = 24'($urandom);
            nb  = $urandom_range(1, 5);
            q   = (c == 8'h6B);
            hdr = (c == 8'h03) ? 32 : 40;
            exp_read(a, nb);
            xact(c, a, 24, hdr - 32, nb * (q ? 2 : 8), -1, 0, 8'h00);
            check($sformatf("rnd%0d_%h", t, c), hdr, q);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
